// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, FSM state encodings, the
// request/response structs and the single-cycle compute function.
// Used by alu_ex_stage and by the ALU controller.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_BNE = 4'b1010;
  localparam logic [3:0] OP_SLT = 4'b1100;
  localparam logic [3:0] OP_BGE = 4'b1101;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_DONE  = 2'd2;

  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } alu_req_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            taken;
    logic            illegal;
  } alu_resp_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Everything that completes in one cycle. Shift ops return src_a, which is
  // the correct answer for a zero shift amount; nonzero shifts are handled
  // by the serial shift unit instead.
  function automatic alu_resp_t alu_compute(input alu_req_t req);
    alu_resp_t r;
    logic      lt;
    r  = '0;
    lt = $signed(req.a) < $signed(req.b);
    case (req.op)
      OP_AND: r.result = req.a & req.b;
      OP_OR:  r.result = req.a | req.b;
      OP_XOR: r.result = req.a ^ req.b;
      OP_ADD: r.result = req.a + req.b;
      OP_SUB: r.result = req.a - req.b;
      OP_SLT: begin
        r.result = {{(XLEN-1){1'b0}}, lt};
        r.taken  = lt;
      end
      OP_BEQ: r.taken = (req.a == req.b);
      OP_BNE: r.taken = (req.a != req.b);
      OP_BGE: r.taken = ~lt;
      OP_SLL, OP_SRL, OP_SRA: r.result = req.a;
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_ex_stage_if.sv
// Handshake bus of the ALU execute stage.
//   master: upstream/downstream side (drives operation, operands, out_ready)
//   slave : the execute stage (drives in_ready, out_valid, result, flags)
interface alu_ex_stage_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        operation;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              branch_taken;
  logic              illegal_op;

  modport master (
    output in_valid, operation, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, branch_taken, illegal_op
  );

  modport slave (
    input  in_valid, operation, src_a, src_b, out_ready,
    output in_ready, out_valid, result, branch_taken, illegal_op
  );
endinterface

// File: rtl/alu_shift_unit.sv
// Serial one-bit-per-cycle shifter.
//   clk, reset : clock, async active-high reset
//   load       : capture data_in, shamt, direction and fill bit
//   left/arith : SLL when left, SRA when arith (fill with data_in MSB)
//   next_data  : value after the current step
//   last       : the current step is the final one
module alu_shift_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              left,
  input  logic              arith,
  input  logic [DATA_W-1:0] data_in,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] next_data,
  output logic              last
);
  logic [DATA_W-1:0] sh_q;
  logic [4:0]        cnt_q;
  logic              fill_q;
  logic              left_q;

  assign next_data = left_q ? {sh_q[DATA_W-2:0], 1'b0} : {fill_q, sh_q[DATA_W-1:1]};
  assign last      = (cnt_q == 5'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      fill_q <= 1'b0;
      left_q <= 1'b0;
    end else if (load) begin
      sh_q   <= data_in;
      cnt_q  <= shamt;
      fill_q <= arith & data_in[DATA_W-1];
      left_q <= left;
    end else if (cnt_q != 5'd0) begin
      sh_q  <= next_data;
      cnt_q <= cnt_q - 5'd1;
    end
  end
endmodule

// File: rtl/alu_ex_stage.sv
// ALU execute stage with valid/ready handshake on both sides.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of alu_ex_stage_if (operation in, result out)
// Single-cycle ops land in DONE one cycle after acceptance; nonzero shifts
// spend shamt cycles in SHIFT first. DONE holds the result until consumed
// and can accept the next operation in the same cycle.
module alu_ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_ex_stage_if.slave bus
);
  state_t            state_q;
  logic [DATA_W-1:0] result_q;
  logic              taken_q;
  logic              illegal_q;

  alu_req_t          req;
  alu_resp_t         resp;
  logic              accept;
  logic              go_shift;
  logic [DATA_W-1:0] sh_next;
  logic              sh_last;

  assign req      = '{op: bus.operation, a: bus.src_a, b: bus.src_b};
  assign resp     = alu_compute(req);
  assign accept   = bus.in_valid && bus.in_ready;
  assign go_shift = is_shift(bus.operation) && (bus.src_b[4:0] != 5'd0);

  assign bus.in_ready     = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign bus.out_valid    = (state_q == S_DONE);
  assign bus.result       = result_q;
  assign bus.branch_taken = taken_q;
  assign bus.illegal_op   = illegal_q;

  // Loaded on every acceptance; only advances while it has a count.
  alu_shift_unit #(.DATA_W(DATA_W)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .left      (bus.operation == OP_SLL),
    .arith     (bus.operation == OP_SRA),
    .data_in   (bus.src_a),
    .shamt     (bus.src_b[4:0]),
    .next_data (sh_next),
    .last      (sh_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (go_shift) begin
              state_q   <= S_SHIFT;
              taken_q   <= 1'b0;
              illegal_q <= 1'b0;
            end else begin
              state_q   <= S_DONE;
              result_q  <= resp.result;
              taken_q   <= resp.taken;
              illegal_q <= resp.illegal;
            end
          end else if (state_q == S_DONE && bus.out_ready) begin
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (sh_last) begin
            state_q  <= S_DONE;
            result_q <= sh_next;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ex_stage.sv
module tb_alu_ex_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_ex_stage_if #(.DATA_W(32)) bus ();
  alu_ex_stage #(.DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        taken;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  // Issue one operation (out_ready=1) from a negedge; returns at the negedge
  // where out_valid is first seen, or after the cycle bound expires.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bus.operation = v.op;
    bus.src_a     = v.a;
    bus.src_b     = v.b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d result", idx), bus.result, v.res);
    chk($sformatf("v%0d taken", idx), {31'b0, bus.branch_taken}, {31'b0, v.taken});
    chk($sformatf("v%0d illegal", idx), {31'b0, bus.illegal_op}, {31'b0, v.ill});
  endtask

  initial begin
    vecs[0]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1};
    vecs[1]  = '{OP_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1};
    vecs[2]  = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
    vecs[3]  = '{OP_OR,  32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1};
    vecs[4]  = '{OP_XOR, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0, 1};
    vecs[5]  = '{OP_SLT, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1};
    vecs[6]  = '{OP_SLT, 32'h00000001, 32'hFFFFFFFE, 32'h00000000, 1'b0, 1'b0, 1};
    vecs[7]  = '{OP_BEQ, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[8]  = '{OP_BNE, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 1'b0, 1};
    vecs[9]  = '{OP_BGE, 32'hFFFFFFFE, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1};
    vecs[10] = '{OP_BGE, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[11] = '{OP_SRA, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 5};
    vecs[12] = '{OP_SRL, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 5};
    vecs[13] = '{OP_SLL, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 32};
    vecs[14] = '{OP_SLL, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 1};
    vecs[15] = '{4'b0110, 32'h12345678, 32'h00000003, 32'h00000000, 1'b0, 1'b1, 1};
    vecs[16] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1};
    vecs[17] = '{OP_SRA, 32'h7FFFFFFF, 32'h00000003, 32'h0FFFFFFF, 1'b0, 1'b0, 4};

    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.operation = 4'h0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("reset result", bus.result, 32'h0);
    chk("reset taken", {31'b0, bus.branch_taken}, 32'h0);
    chk("reset illegal", {31'b0, bus.illegal_op}, 32'h0);
    chk("reset in_ready", {31'b0, bus.in_ready}, 32'h1);

    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("idle after table", {31'b0, bus.out_valid}, 32'h0);

    // Back-to-back SUB then XOR with no bubble
    bus.operation = OP_SUB; bus.src_a = 32'd5; bus.src_b = 32'd7;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.operation = OP_XOR; bus.src_a = 32'hF0; bus.src_b = 32'h0F;
    chk("b2b first valid", {31'b0, bus.out_valid}, 32'h1);
    chk("b2b first result", bus.result, 32'hFFFFFFFE);
    chk("b2b in_ready", {31'b0, bus.in_ready}, 32'h1);
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b second valid", {31'b0, bus.out_valid}, 32'h1);
    chk("b2b second result", bus.result, 32'h000000FF);
    @(posedge clk); @(negedge clk);
    chk("b2b back to idle", {31'b0, bus.out_valid}, 32'h0);

    // Backpressure: result held while out_ready=0, new inputs ignored
    bus.operation = OP_OR; bus.src_a = 32'h1; bus.src_b = 32'h2;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.operation = OP_AND; bus.src_a = 32'h0; bus.src_b = 32'h0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp valid c%0d", c), {31'b0, bus.out_valid}, 32'h1);
      chk($sformatf("bp result c%0d", c), bus.result, 32'h3);
      chk($sformatf("bp in_ready c%0d", c), {31'b0, bus.in_ready}, 32'h0);
      @(posedge clk); @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("bp release result", bus.result, 32'h3);
    @(posedge clk); @(negedge clk);
    chk("bp drained", {31'b0, bus.out_valid}, 32'h0);

    // Inputs changing during SHIFT must not disturb the captured op
    bus.operation = OP_SRL; bus.src_a = 32'hF0; bus.src_b = 32'd4;
    bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.operation = OP_SLL; bus.src_a = 32'hDEADBEEF; bus.src_b = 32'd1;
    chk("shift in_ready", {31'b0, bus.in_ready}, 32'h0);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("shift hold valid", {31'b0, bus.out_valid}, 32'h1);
    chk("shift hold result", bus.result, 32'h0000000F);
    @(posedge clk); @(negedge clk);

    // Reset two cycles into SLL by 20 kills it; next AND has latency 1
    bus.operation = OP_SLL; bus.src_a = 32'h1; bus.src_b = 32'd20;
    bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sll in shift", {31'b0, bus.in_ready}, 32'h0);
    reset = 1'b1;
    #1;
    chk("async reset valid", {31'b0, bus.out_valid}, 32'h0);
    chk("async reset in_ready", {31'b0, bus.in_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    bus.operation = OP_AND; bus.src_a = 32'hF0F0; bus.src_b = 32'hFF00;
    bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    chk("post reset and valid", {31'b0, bus.out_valid}, 32'h1);
    chk("post reset and result", bus.result, 32'h0000F000);
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < 22; c++) begin
      if (bus.out_valid) begin
        n_checks++;
        n_fail++;
        $display("FAIL stale sll output at cycle %0d: got out_valid=1, expected 0", c);
      end
      @(negedge clk);
    end
    chk("no stale sll", {31'b0, bus.out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
